// File: rtl/display_scanner_pkg.sv
// Shared constants for the multiplexed 3-digit display: select codes,
// blank pattern and the active-low 7-segment table ({g,f,e,d,c,b,a}).
package display_scanner_pkg;

    localparam logic [1:0] IDX_0 = 2'd0;
    localparam logic [1:0] IDX_1 = 2'd1;
    localparam logic [1:0] IDX_2 = 2'd2;

    // {SEL1,SEL0}; 11 is reserved for "no digit selected"
    localparam logic [1:0] SEL_IDX0  = 2'b00;
    localparam logic [1:0] SEL_IDX1  = 2'b10;
    localparam logic [1:0] SEL_IDX2  = 2'b01;
    localparam logic [1:0] SEL_BLANK = 2'b11;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_DIGIT0 = 7'b1000000;
    localparam logic [6:0] SEG_DIGIT1 = 7'b1111001;
    localparam logic [6:0] SEG_DIGIT2 = 7'b0100100;
    localparam logic [6:0] SEG_DIGIT3 = 7'b0110000;
    localparam logic [6:0] SEG_DIGIT4 = 7'b0011001;
    localparam logic [6:0] SEG_DIGIT5 = 7'b0010010;
    localparam logic [6:0] SEG_DIGIT6 = 7'b0000010;
    localparam logic [6:0] SEG_DIGIT7 = 7'b1111000;
    localparam logic [6:0] SEG_DIGIT8 = 7'b0000000;
    localparam logic [6:0] SEG_DIGIT9 = 7'b0010000;

endpackage

// File: rtl/display_scanner_seg7_decoder.sv
// Combinational BCD to active-low 7-segment decode; non-BCD codes blank.
module seg7_decoder
    import display_scanner_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_DIGIT0;
            4'd1: seg = SEG_DIGIT1;
            4'd2: seg = SEG_DIGIT2;
            4'd3: seg = SEG_DIGIT3;
            4'd4: seg = SEG_DIGIT4;
            4'd5: seg = SEG_DIGIT5;
            4'd6: seg = SEG_DIGIT6;
            4'd7: seg = SEG_DIGIT7;
            4'd8: seg = SEG_DIGIT8;
            4'd9: seg = SEG_DIGIT9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed scanner for a 3-digit common-select 7-segment display with
// per-slot blanking, frame-coherent digit snapshots and leading-zero blanking.
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic       CLK,
    input  logic       NRST,
    input  logic       EN,
    input  logic       LZB,
    input  logic [3:0] DIG0,
    input  logic [3:0] DIG1,
    input  logic [3:0] DIG2,
    output logic       SEL0,
    output logic       SEL1,
    output logic [6:0] SEG,
    output logic       FRAME
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    s0, s1, s2;
    logic [1:0]    sel_q;
    logic [6:0]    seg_q;
    logic          frame_q;

    logic [3:0]    cur;
    logic [6:0]    dec_seg;
    logic [1:0]    slot_sel;
    logic          lz_blank;
    logic          load;
    logic          shown;
    logic [1:0]    sel_next;
    logic [6:0]    seg_next;

    seg7_decoder u_dec (
        .bcd (cur),
        .seg (dec_seg)
    );

    always_comb begin
        cur      = 4'hF;
        slot_sel = SEL_BLANK;
        lz_blank = 1'b0;
        case (idx)
            IDX_0: begin
                cur      = s0;
                slot_sel = SEL_IDX0;
            end
            IDX_1: begin
                cur      = s1;
                slot_sel = SEL_IDX1;
                lz_blank = LZB && (s2 == 4'd0) && (s1 == 4'd0);
            end
            IDX_2: begin
                cur      = s2;
                slot_sel = SEL_IDX2;
                lz_blank = LZB && (s2 == 4'd0);
            end
            default: ;
        endcase

        load     = EN && (cnt == '0) && (idx == IDX_0);
        shown    = EN && (cnt >= CNT_BLANK);
        sel_next = SEL_BLANK;
        seg_next = SEG_BLANK;
        if (shown) begin
            sel_next = slot_sel;
            seg_next = lz_blank ? SEG_BLANK : dec_seg;
        end
    end

    // Outputs are registered from the pre-edge CNT/IDX, one cycle behind the counter
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            cnt     <= '0;
            idx     <= IDX_0;
            s0      <= '0;
            s1      <= '0;
            s2      <= '0;
            sel_q   <= SEL_BLANK;
            seg_q   <= SEG_BLANK;
            frame_q <= 1'b0;
        end else begin
            sel_q   <= sel_next;
            seg_q   <= seg_next;
            frame_q <= load;
            if (EN) begin
                if (load) begin
                    s0 <= DIG0;
                    s1 <= DIG1;
                    s2 <= DIG2;
                end
                if (cnt == CNT_LAST) begin
                    cnt <= '0;
                    idx <= (idx == IDX_2) ? IDX_0 : idx + 2'd1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign SEL1  = sel_q[1];
    assign SEL0  = sel_q[0];
    assign SEG   = seg_q;
    assign FRAME = frame_q;

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter DIV, default 50000: clock cycles per digit slot; legal range DIV >= 2.
REQ-002 Parameter BLANK, default 16: blanked cycles at the start of each slot; legal range 1 <= BLANK < DIV.
REQ-003 CLK  input  1  sole clock; all state changes on the rising edge.
REQ-004 NRST  input  1  asynchronous, active-low reset.
REQ-005 EN  input  1  scan enable; when 0, the scan freezes and the display is blanked.
REQ-006 LZB  input  1  leading-zero blanking enable.
REQ-007 DIG0, DIG1, DIG2  input  4 each  BCD digits; DIG2 is most significant.
REQ-008 SEL0, SEL1  output  1 each  digit select code, feeds the digit selector.
REQ-009 SEG  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-010 FRAME  output  1  one-cycle pulse marking a new input snapshot.

Function
REQ-011 State SHALL consist of slot counter CNT (0..DIV-1), digit index IDX (0,1,2), and shadow registers S0..S2.
REQ-012 While EN=1, CNT SHALL increment each cycle; at DIV-1 it SHALL wrap to 0 and IDX SHALL advance 0->1->2->0.
REQ-013 While EN=0, CNT, IDX and the shadows SHALL hold, and the registered outputs SHALL be SEL1SEL0=11 and SEG=7'h7F.
REQ-014 When CNT < BLANK, the outputs SHALL be blank: SEL1SEL0=11 and SEG=7'h7F.
REQ-015 When CNT >= BLANK, SEL1SEL0 SHALL be 00 for IDX 0, 10 for IDX 1, and 01 for IDX 2; code 11 is reserved for blank.
REQ-016 When CNT >= BLANK, SEG SHALL be the active-low decode of the shadow value for IDX.
REQ-017 Decode table (gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 Any value 10..15 SHALL decode to 1111111 (blank).
REQ-019 On an enabled edge where CNT=0 and IDX=0, S0..S2 SHALL load DIG0..DIG2; there is no other shadow update, so a frame is always coherent.
REQ-020 FRAME SHALL be 1 for exactly the cycle following each shadow-load edge, and 0 otherwise.
REQ-021 With LZB=1, slot 2 SHALL blank SEG when S2=0, and slot 1 SHALL blank SEG when S2=0 and S1=0.
REQ-022 Under LZB, slot 0 is never blanked, and SEL SHALL keep the slot code.
REQ-023 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-024 Output timing: the outputs in cycle n SHALL reflect CNT/IDX/EN as sampled at edge n.

Reset
REQ-025 NRST=0 SHALL immediately, without a clock edge, force SEL0=1, SEL1=1, SEG=7'h7F and FRAME=0.
REQ-026 NRST=0 SHALL clear CNT, IDX and S0..S2 to 0.
REQ-027 After NRST rises, the first enabled edge SHALL be a shadow-load edge.
REQ-028 Reset asserted mid-slot or mid-frame SHALL abandon that slot; no partial state is retained.

Structure
REQ-029 Select codes (00/10/01/11), the blank pattern 7'h7F and the decode table SHALL live in a shared constants include used by display_scanner and the digit selector.
REQ-030 The BCD-to-segment decode SHALL be one combinational sub-module, seg7_decoder (4-bit in, 7-bit active-low out, blank for 10..15).
REQ-031 The CNT width SHALL be derived from DIV by $clog2.

Verification (DIV=8, BLANK=2)
REQ-032 Reset, EN=1, DIG2/1/0=3/2/1 -> per 8-cycle slot, 2 cycles of 11/7F then 6 cycles of 00/1111001, 10/0100100, 01/0110000; FRAME pulses every 24 cycles.
REQ-033 Change DIG0 to 5 during the IDX 1 slot -> slot 0 keeps showing 1 until the next FRAME, then shows 0010010.
REQ-034 LZB=1, DIG=0/0/7 -> slots 2 and 1 give SEG=7F with SEL codes 01/10, slot 0 shows 1111000; with DIG=0/0/0, slot 0 shows 1000000.
REQ-035 EN=0 for 5 cycles at CNT=4 of slot 1 -> 11/7F for 5 cycles, then resume at CNT=4 of slot 1 with no FRAME.
REQ-036 NRST low between edges mid-show -> SEL=11 and SEG=7F within the same cycle; after release, FRAME follows the first enabled edge.
REQ-037 DIG1=4'hA -> slot 1 shows SEG=7F with SEL1SEL0=10.
